keypad_matrix_scanner: RTL and testbench

Parametrised successor to the team's 4x4 keypad encoder. It scans a ROWS x COLS active-low key matrix from a single clock domain using a tick enable, with no derived clocks. Each key is debounced on press and on release. Press events go into a small FIFO and are presented to the consuming logic over a valid/ready handshake, together with a held-key level and a keystroke counter.

---
 rtl/keypad_pkg.sv | 15 +
 rtl/keypad_event_fifo.sv | 47 ++++
 rtl/keypad_matrix_scanner.sv | 207 ++++++++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared FSM state type and key-code width helper for the keypad matrix scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SCAN     = 2'd1,
        ST_PRESS_DB = 2'd2,
        ST_HELD     = 2'd3
    } kp_state_e;

    function automatic int kp_code_w(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Key-event FIFO between the scanner FSM and the consumer; pushes into a full FIFO are dropped
// unless a pop frees a slot in the same cycle.
module keypad_event_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    always_comb begin
        valid    = (wr_ptr_q != rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && valid;
        // The slot freed by a same-cycle pop is the one being written, so full+pop still accepts.
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        head     = valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Tick-driven ROWS x COLS keypad scanner with press/release debounce and a press-event FIFO.
// Define KEYPAD_AUTOREPEAT_EN to add auto-repeat of the held key (REPEAT_DELAY / REPEAT_RATE).
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SCAN_DIV     = 500000,
    parameter int DEBOUNCE     = 3,
    parameter int FIFO_DEPTH   = 4,
`ifdef KEYPAD_AUTOREPEAT_EN
    parameter int REPEAT_DELAY = 25,
    parameter int REPEAT_RATE  = 5,
`endif
    parameter int CODE_W       = kp_code_w(ROWS, COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   col,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_held,
    output logic              overflow,
    output logic [7:0]        keystrokes
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    logic [ROWS-1:0]   row_p0_q, row_p1_q;
    logic [DIV_W-1:0]  div_q, div_d;
    kp_state_e         state_q, state_d;
    logic [CW-1:0]     col_idx_q, col_idx_d;
    logic [RW-1:0]     row_idx_q, row_idx_d, low_idx;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        keystrokes_q, keystrokes_d;
    logic              overflow_q, overflow_d;
    logic              tick, any_low, confirm, rpt, push, pop, fifo_full;
    logic [CODE_W-1:0] code;

    always_comb begin
        tick    = (div_q == DIV_W'(SCAN_DIV - 1));
        div_d   = tick ? '0 : div_q + DIV_W'(1);
        any_low = ~&row_p1_q;
        low_idx = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!row_p1_q[i]) low_idx = RW'(i);
        end
    end

    // One key is tracked at a time; the shared counter debounces the press, then the release.
    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        row_idx_d = row_idx_q;
        cnt_d     = cnt_q;
        confirm   = 1'b0;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (any_low) begin
                        state_d   = ST_SCAN;
                        col_idx_d = '0;
                    end
                end
                ST_SCAN: begin
                    if (any_low) begin
                        row_idx_d = low_idx;
                        if (DEBOUNCE == 1) begin
                            confirm = 1'b1;
                            state_d = ST_HELD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = ST_PRESS_DB;
                        end
                    end else if (col_idx_q < CW'(COLS - 1)) begin
                        col_idx_d = col_idx_q + CW'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PRESS_DB: begin
                    if (any_low && low_idx == row_idx_q) begin
                        if (cnt_q + CNT_W'(1) == CNT_W'(DEBOUNCE)) begin
                            confirm = 1'b1;
                            state_d = ST_HELD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    if (!any_low) begin
                        if (cnt_q + CNT_W'(1) == CNT_W'(DEBOUNCE)) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            endcase
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             rep_first_q, rep_first_d;

    always_comb begin
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
        rpt         = 1'b0;
        if (confirm) begin
            rep_d       = '0;
            rep_first_d = 1'b1;
        end else if (tick && state_q == ST_HELD) begin
            if (!row_p1_q[row_idx_q]) begin
                rep_d = rep_q + REP_W'(1);
                if (rep_d == (rep_first_q ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_RATE))) begin
                    rpt         = 1'b1;
                    rep_d       = '0;
                    rep_first_d = 1'b0;
                end
            end else begin
                rep_d       = '0;
                rep_first_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_q       <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
        end
    end
`else
    always_comb rpt = 1'b0;
`endif

    always_comb begin
        code         = CODE_W'(col_idx_q) * CODE_W'(ROWS) + CODE_W'(row_idx_d);
        push         = confirm | rpt;
        pop          = key_valid & key_ready;
        keystrokes_d = keystrokes_q + {7'd0, confirm};
        overflow_d   = overflow_q | (push & fifo_full & ~pop);
        col          = (state_q == ST_IDLE) ? '0 : ~(COLS'(1) << col_idx_q);
        key_held     = (state_q == ST_HELD);
        overflow     = overflow_q;
        keystrokes   = keystrokes_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_p0_q     <= '1;
            row_p1_q     <= '1;
            div_q        <= '0;
            state_q      <= ST_IDLE;
            col_idx_q    <= '0;
            row_idx_q    <= '0;
            cnt_q        <= '0;
            keystrokes_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            row_p0_q     <= row;
            row_p1_q     <= row_p0_q;
            div_q        <= div_d;
            state_q      <= state_d;
            col_idx_q    <= col_idx_d;
            row_idx_q    <= row_idx_d;
            cnt_q        <= cnt_d;
            keystrokes_q <= keystrokes_d;
            overflow_q   <= overflow_d;
        end
    end

    keypad_event_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (code),
        .full      (fifo_full),
        .pop       (pop),
        .valid     (key_valid),
        .head      (key_code)
    );

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: table of single presses, FIFO overflow/full-pop sequences,
// randomized presses against a queue model, and auto-repeat when KEYPAD_AUTOREPEAT_EN is defined.
module tb_keypad_matrix_scanner;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int SD = 4;
    localparam int DB = 3;
    localparam int FD = 4;
    localparam int CW = $clog2(R * C);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [R-1:0]  row;
    logic [C-1:0]  col;
    logic [CW-1:0] key_code;
    logic          key_valid;
    logic          key_ready = 1'b0;
    logic          key_held;
    logic          overflow;
    logic [7:0]    keystrokes;

    logic [R-1:0]  pressed [C];
    logic          force_en = 1'b0;
    logic [R-1:0]  force_row = '1;

    int   total = 0, bad = 0, cyc = 0, last_conf = 0, pops = 0, pulse_at = -1, conf5 = 0;
    logic [7:0] ks_prev = '0;
    bit   rnd_ready = 0, pulse_en = 0, track = 0;
    int   exp_q[$];

    typedef struct {
        int c;
        int r;
        int hold;
        int exp_evt;
    } vec_t;
    vec_t tv[5];

    int kc[5] = '{0, 1, 2, 3, 1};
    int kr[5] = '{0, 2, 1, 3, 0};

    always #5 clk = ~clk;

    // Physical matrix: a pressed key shorts its row low while its column is driven low.
    always_comb begin
        row = '1;
        for (int c = 0; c < C; c++) begin
            if (!col[c]) row = row & ~pressed[c];
        end
        if (force_en) row = force_row;
    end

    keypad_matrix_scanner #(
        .ROWS       (R),
        .COLS       (C),
        .SCAN_DIV   (SD),
        .DEBOUNCE   (DB),
        .FIFO_DEPTH (FD)
`ifdef KEYPAD_AUTOREPEAT_EN
        , .REPEAT_DELAY (4)
        , .REPEAT_RATE  (2)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .row        (row),
        .col        (col),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_held   (key_held),
        .overflow   (overflow),
        .keystrokes (keystrokes)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        if (rnd_ready) key_ready = 1'($urandom_range(0, 1));
        if (pulse_en)  key_ready = (cyc == pulse_at);
        if (track && key_valid && key_ready) begin
            pops++;
            if (exp_q.size() == 0) check("pop_unexpected", int'(key_code), -1);
            else                   check("pop_code", int'(key_code), exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        cyc++;
        if (keystrokes != ks_prev) last_conf = cyc;
        ks_prev = keystrokes;
    endtask

    task automatic ticks(input int n);
        repeat (n * SD) step();
    endtask

    task automatic do_reset();
        key_ready = 1'b0;
        reset     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b1;
        cyc       = 0;
        last_conf = 0;
        ks_prev   = keystrokes;
    endtask

    task automatic drain(input int n);
        key_ready = 1'b1;
        repeat (n) step();
        key_ready = 1'b0;
    endtask

    task automatic run_five();
        for (int k = 0; k < 5; k++) begin
            pressed[kc[k]][kr[k]] = 1'b1;
            ticks(12);
            pressed[kc[k]][kr[k]] = 1'b0;
            ticks(6);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int ks0, c, r, w;
        for (int i = 0; i < C; i++) pressed[i] = '0;
        tv[0] = '{c: 2, r: 1, hold: 12, exp_evt: 1};
        tv[1] = '{c: 0, r: 0, hold: 2,  exp_evt: 0};
        tv[2] = '{c: 3, r: 3, hold: 12, exp_evt: 1};
        tv[3] = '{c: 1, r: 2, hold: 2,  exp_evt: 0};
        tv[4] = '{c: 0, r: 3, hold: 12, exp_evt: 1};

        // Reset with the row lines toggling
        #2 reset = 1'b0;
        force_en = 1'b1;
        repeat (6) begin
            force_row = R'($urandom);
            @(posedge clk);
            #1;
        end
        check("rst_col", int'(col), 0);
        check("rst_code", int'(key_code), 0);
        check("rst_valid", int'(key_valid), 0);
        check("rst_held", int'(key_held), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_keystrokes", int'(keystrokes), 0);
        force_en = 1'b0;
        reset    = 1'b1;
        cyc      = 0;
        ks_prev  = keystrokes;
        ticks(10);
        check("idle_col", int'(col), 0);
        check("idle_valid", int'(key_valid), 0);
        check("idle_keystrokes", int'(keystrokes), 0);

        // Table of single presses, including short bounces that must be rejected
        for (int i = 0; i < 5; i++) begin
            ks0 = int'(keystrokes);
            pressed[tv[i].c][tv[i].r] = 1'b1;
            ticks(tv[i].hold);
            check($sformatf("tv%0d_held", i), int'(key_held), tv[i].exp_evt);
            pressed[tv[i].c][tv[i].r] = 1'b0;
            ticks(6);
            check($sformatf("tv%0d_released", i), int'(key_held), 0);
            check($sformatf("tv%0d_idle_col", i), int'(col), 0);
            check($sformatf("tv%0d_keystrokes", i), int'(keystrokes), (ks0 + tv[i].exp_evt) % 256);
            check($sformatf("tv%0d_valid", i), int'(key_valid), tv[i].exp_evt);
            if (tv[i].exp_evt != 0) begin
                check($sformatf("tv%0d_code", i), int'(key_code), tv[i].c * R + tv[i].r);
                key_ready = 1'b1;
                step();
                key_ready = 1'b0;
                ticks(4);
                check($sformatf("tv%0d_no_second", i), int'(key_valid), 0);
            end
        end

        // Five presses with the consumer stalled: four retained, one dropped
        do_reset();
        run_five();
        conf5 = last_conf;
        check("ovf_flag", int'(overflow), 1);
        check("ovf_keystrokes", int'(keystrokes), 5);
        check("ovf_valid", int'(key_valid), 1);
        exp_q = '{0, 6, 9, 15};
        pops  = 0;
        track = 1;
        drain(12);
        check("ovf_pops", pops, 4);
        check("ovf_left", exp_q.size(), 0);
        check("ovf_empty", int'(key_valid), 0);

        // Same run, but pop on exactly the cycle of the fifth confirm while full
        do_reset();
        exp_q    = '{0, 6, 9, 15, 4};
        pops     = 0;
        pulse_at = conf5 - 1;
        pulse_en = 1;
        run_five();
        pulse_en  = 0;
        key_ready = 1'b0;
        check("fullpop_pops", pops, 1);
        check("fullpop_overflow", int'(overflow), 0);
        check("fullpop_keystrokes", int'(keystrokes), 5);
        drain(12);
        check("fullpop_total_pops", pops, 5);
        check("fullpop_left", exp_q.size(), 0);

        // Randomized presses, random consumer back-pressure, queue model of expected codes
        do_reset();
        exp_q.delete();
        pops      = 0;
        rnd_ready = 1;
        for (int n = 0; n < 6; n++) begin
            c = $urandom_range(0, C - 1);
            r = $urandom_range(0, R - 1);
            exp_q.push_back(c * R + r);
            pressed[c][r] = 1'b1;
            repeat ($urandom_range(12 * SD, 15 * SD)) step();
            pressed[c][r] = 1'b0;
            ticks(7);
        end
        rnd_ready = 0;
        drain(12);
        check("rand_pops", pops, 6);
        check("rand_left", exp_q.size(), 0);
        check("rand_keystrokes", int'(keystrokes), 6);
        check("rand_overflow", int'(overflow), 0);

`ifdef KEYPAD_AUTOREPEAT_EN
        // Held key: one press event plus repeats 4, 6, 8 and 10 ticks after the confirm
        do_reset();
        exp_q     = '{5, 5, 5, 5, 5};
        pops      = 0;
        key_ready = 1'b1;
        pressed[1][1] = 1'b1;
        w = 0;
        while (keystrokes == 8'd0 && w < 200) begin
            step();
            w++;
        end
        check("rpt_confirm", int'(keystrokes), 1);
        repeat (10 * SD - 1) step();
        pressed[1][1] = 1'b0;
        ticks(6);
        key_ready = 1'b0;
        check("rpt_pops", pops, 5);
        check("rpt_left", exp_q.size(), 0);
        check("rpt_keystrokes", int'(keystrokes), 1);
        check("rpt_overflow", int'(overflow), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
